// File: rtl/txd_check_if.sv
// AXI-Stream beat channel from the DMA MM2S path into the pattern checker.
interface txd_check_if;
  logic [31:0] axi_str_tdata;
  logic        axi_str_tlast;
  logic        axi_str_tvalid;
  logic        axi_str_tready;

  modport master (
    output axi_str_tdata,
    output axi_str_tlast,
    output axi_str_tvalid,
    input  axi_str_tready
  );

  modport slave (
    input  axi_str_tdata,
    input  axi_str_tlast,
    input  axi_str_tvalid,
    output axi_str_tready
  );
endinterface

// File: rtl/txd_check.sv
// Pattern checker: verifies incrementing frames with TLAST on word FRAME_LEN-1, 1-cycle result latency.
// Backpressure: registered tready, 2-cycle gap after each TLAST; optional TXD_THROTTLE_EN drops tready every 4th RECV cycle.
module txd_check #(
  parameter int unsigned FRAME_LEN    = 256,
  parameter logic [31:0] KEYHOLE_ADDR = 32'h8001_2000,
  parameter int unsigned ERR_W        = 16
) (
  input  logic             aclk,
  input  logic             areset,
  txd_check_if.slave       axi_str,
  input  logic             tx_enable,
  output logic [1:0]       state,
  output logic             frame_done,
  output logic [31:0]      frame_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [31:0]      keyhole_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  localparam logic [31:0] LAST_IDX = 32'(FRAME_LEN - 1);

  state_e           state_q;
  logic             tready_q;
  logic             frame_done_q;
  logic [31:0]      frame_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             err_sticky_q;
  logic [31:0]      exp_q;

  logic             beat;
  logic             data_err;
  logic             last_err;
  logic             beat_err;
  logic [31:0]      exp_d;
  logic [31:0]      frame_cnt_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic             tready_recv_d;

  assign beat        = axi_str.axi_str_tvalid & tready_q;
  assign data_err    = axi_str.axi_str_tdata != exp_q;
  assign last_err    = axi_str.axi_str_tlast != (exp_q == LAST_IDX);
  assign beat_err    = beat & (data_err | last_err);
  assign exp_d       = exp_q + 32'd1;
  assign frame_cnt_d = frame_cnt_q + 32'd1;
  assign err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

`ifdef TXD_THROTTLE_EN
  logic [1:0] thr_q;
  logic [1:0] thr_d;

  assign thr_d = thr_q + 2'd1;
  // tready is registered, so look one count ahead to drop it on the 4th cycle.
  assign tready_recv_d = (thr_d != 2'd3);

  always_ff @(posedge aclk) begin
    if (areset || state_q != S_RECV) begin
      thr_q <= 2'd0;
    end else begin
      thr_q <= thr_d;
    end
  end
`else
  assign tready_recv_d = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      exp_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          exp_q <= '0;
          if (tx_enable) begin
            state_q  <= S_RECV;
            tready_q <= 1'b1;
          end else begin
            tready_q <= 1'b0;
          end
        end
        S_RECV: begin
          if (beat_err) begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= 1'b1;
          end
          if (beat && axi_str.axi_str_tlast) begin
            state_q      <= S_DONE;
            tready_q     <= 1'b0;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_d;
            exp_q        <= '0;
          end else begin
            if (beat) begin
              exp_q <= exp_d;
            end
            // Abort takes effect after any beat on this edge has been checked.
            if (!tx_enable) begin
              state_q  <= S_IDLE;
              tready_q <= 1'b0;
            end else begin
              tready_q <= tready_recv_d;
            end
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          tready_q <= 1'b0;
        end
        S_BAD: begin
          state_q  <= S_IDLE;
          tready_q <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign axi_str.axi_str_tready = tready_q;
  assign state                  = state_q;
  assign frame_done             = frame_done_q;
  assign frame_cnt              = frame_cnt_q;
  assign err_cnt                = err_cnt_q;
  assign err_sticky             = err_sticky_q;
  assign keyhole_addr           = KEYHOLE_ADDR;

endmodule

// File: tb/tb_txd_check.sv
// Randomized bench for txd_check against a transaction-level reference model.
module tb_txd_check;
  localparam int FL = 256;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        tx_enable = 1'b0;
  logic [1:0]  state;
  logic        frame_done;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;
  logic [31:0] keyhole_addr;

  txd_check_if axi();

  txd_check dut (
    .aclk         (aclk),
    .areset       (areset),
    .axi_str      (axi),
    .tx_enable    (tx_enable),
    .state        (state),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .err_sticky   (err_sticky),
    .keyhole_addr (keyhole_addr)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int recv_cycles = 0;

  // Reference model: mode 0 idle, 1 receiving, 2 frame just finished.
  bit          m_valid = 1'b0;
  int          m_mode;
  bit          m_rdy;
  bit          m_done;
  int unsigned m_frames;
  int unsigned m_errs;
  bit          m_sticky;
  int unsigned m_exp;
  int unsigned m_recv_age;

  always @(posedge aclk) begin
    bit accepted, bad;
    if (areset) begin
      m_valid = 1'b1;
      m_mode = 0; m_rdy = 0; m_done = 0; m_frames = 0;
      m_errs = 0; m_sticky = 0; m_exp = 0; m_recv_age = 0;
    end else if (m_valid) begin
      m_done = 0;
      if (m_mode == 0) begin
        m_exp = 0;
        m_rdy = tx_enable;
        if (tx_enable) begin
          m_mode = 1;
          m_recv_age = 0;
        end
      end else if (m_mode == 1) begin
        accepted = axi.axi_str_tvalid && m_rdy;
        if (accepted) begin
          bad = (axi.axi_str_tdata != m_exp) || (axi.axi_str_tlast != (m_exp == FL - 1));
          if (bad) begin
            if (m_errs < 65535) m_errs++;
            m_sticky = 1;
          end
        end
        if (accepted && axi.axi_str_tlast) begin
          m_frames++;
          m_exp = 0;
          m_mode = 2;
          m_rdy = 0;
          m_done = 1;
        end else begin
          if (accepted) m_exp++;
          if (!tx_enable) begin
            m_mode = 0;
            m_rdy = 0;
          end else begin
            m_recv_age++;
`ifdef TXD_THROTTLE_EN
            m_rdy = (m_recv_age % 4) != 3;
`else
            m_rdy = 1;
`endif
          end
        end
      end else begin
        m_mode = 0;
        m_rdy = 0;
      end
    end
  end

  always @(negedge aclk) begin
    if (m_valid) begin
      checks++;
      if (state !== 2'(m_mode) || axi.axi_str_tready !== m_rdy || frame_done !== m_done ||
          frame_cnt !== m_frames || err_cnt !== 16'(m_errs) || err_sticky !== m_sticky ||
          keyhole_addr !== 32'h8001_2000) begin
        errors++;
        $display("FAIL cycle_model t=%0t dut st=%0d rdy=%0b done=%0b fc=%0d ec=%0d stk=%0b kh=%h expected st=%0d rdy=%0b done=%0b fc=%0d ec=%0d stk=%0b kh=80012000",
                 $time, state, axi.axi_str_tready, frame_done, frame_cnt, err_cnt, err_sticky, keyhole_addr,
                 m_mode, m_rdy, m_done, m_frames, m_errs, m_sticky);
      end
      if (frame_done === 1'b1) done_pulses++;
      if (state === 2'd1) recv_cycles++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input int gap_pct);
    bit r;
    int n;
    while (int'($urandom_range(99)) < gap_pct) begin
      axi.axi_str_tvalid = 1'b0;
      axi.axi_str_tdata  = $urandom;
      axi.axi_str_tlast  = 1'($urandom);
      tick();
    end
    axi.axi_str_tvalid = 1'b1;
    axi.axi_str_tdata  = d;
    axi.axi_str_tlast  = l;
    n = 0;
    forever begin
      @(negedge aclk);
      r = axi.axi_str_tready;
      @(posedge aclk);
      #1;
      if (r) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout word=%0h tready never seen within 20 cycles", d);
        break;
      end
    end
    axi.axi_str_tvalid = 1'b0;
    axi.axi_str_tdata  = $urandom;
    axi.axi_str_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int gap, input int bad_idx, input logic [31:0] bad_val, input int last_idx);
    for (int i = 0; i <= last_idx; i++) begin
      send_word((i == bad_idx) ? bad_val : 32'(i), i == last_idx, gap);
    end
  endtask

  task automatic do_reset();
    tx_enable = 1'b0;
    axi.axi_str_tvalid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, cnt;
    axi.axi_str_tvalid = 1'b0;
    axi.axi_str_tdata  = '0;
    axi.axi_str_tlast  = 1'b0;
    tick();
    tick();
    areset = 1'b0;

    check("reset_state", 64'(state), 64'd0);
    check("reset_tready", 64'(axi.axi_str_tready), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("keyhole_addr", 64'(keyhole_addr), 64'h8001_2000);

    // Clean frame, continuous tvalid.
    p0 = done_pulses;
    tx_enable = 1'b1;
    send_frame(0, -1, 32'd0, FL - 1);
    tx_enable = 1'b0;
    repeat (3) tick();
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);
    check("t1_done_pulses", 64'(done_pulses - p0), 64'd1);
    do_reset();

    // Corrupted word 17.
    tx_enable = 1'b1;
    send_frame(0, 17, 32'hDEAD, FL - 1);
    repeat (3) tick();
    check("t2_err_cnt", 64'(err_cnt), 64'd1);
    check("t2_err_sticky", 64'(err_sticky), 64'd1);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    do_reset();

    // Early TLAST then a clean frame.
    tx_enable = 1'b1;
    send_frame(0, -1, 32'd0, 100);
    repeat (2) tick();
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd1);
    send_frame(0, -1, 32'd0, FL - 1);
    repeat (3) tick();
    check("t3_err_after_clean", 64'(err_cnt), 64'd1);
    check("t3_frame_cnt2", 64'(frame_cnt), 64'd2);
    do_reset();

    // Random tvalid gaps over four clean frames.
    p0 = done_pulses;
    tx_enable = 1'b1;
    repeat (4) send_frame(50, -1, 32'd0, FL - 1);
    repeat (3) tick();
    check("t4_frame_cnt", 64'(frame_cnt), 64'd4);
    check("t4_err_cnt", 64'(err_cnt), 64'd0);
    check("t4_done_pulses", 64'(done_pulses - p0), 64'd4);

    // Reset in the middle of a frame.
    for (int i = 0; i < 50; i++) send_word(32'(i), 1'b0, 0);
    areset = 1'b1;
    axi.axi_str_tvalid = 1'b1;
    axi.axi_str_tdata  = 32'd50;
    tick();
    areset = 1'b0;
    axi.axi_str_tvalid = 1'b0;
    check("t5_state", 64'(state), 64'd0);
    check("t5_tready", 64'(axi.axi_str_tready), 64'd0);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_frame_done", 64'(frame_done), 64'd0);
    send_frame(0, -1, 32'd0, FL - 1);
    repeat (3) tick();
    check("t5_resend_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t5_resend_err_cnt", 64'(err_cnt), 64'd0);
    do_reset();

    // RECV cycle count for one frame under continuous tvalid.
    tick();
    recv_cycles = 0;
    tx_enable = 1'b1;
    send_frame(0, -1, 32'd0, FL - 1);
    tx_enable = 1'b0;
    cnt = recv_cycles;
`ifdef TXD_THROTTLE_EN
    check("t6_recv_cycles", 64'(cnt), 64'd341);
`else
    check("t6_recv_cycles", 64'(cnt), 64'd256);
`endif
    repeat (2) tick();
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
    do_reset();

    // Random frames: random length (some over-long), random corruption, aborts.
    tx_enable = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int len, bad;
      len = (f % 3 == 0) ? FL : int'($urandom_range(1, FL + 40));
      bad = ($urandom_range(1) != 0) ? int'($urandom_range(0, len - 1)) : -1;
      if (f == 5) begin
        for (int i = 0; i < 30; i++) send_word(32'(i), 1'b0, 20);
        tx_enable = 1'b0;
        repeat (3) tick();
        tx_enable = 1'b1;
      end
      send_frame(30, bad, $urandom, len - 1);
    end
    repeat (3) tick();
    tx_enable = 1'b0;
    repeat (2) tick();
    do_reset();

    // Error counter saturation.
    tx_enable = 1'b1;
    axi.axi_str_tvalid = 1'b1;
    axi.axi_str_tdata  = 32'hFFFF_FFFF;
    axi.axi_str_tlast  = 1'b0;
    for (int i = 0; i < 90000; i++) begin
      tick();
      if (err_cnt === 16'hFFFF) break;
    end
    repeat (20) tick();
    check("t7_err_saturated", 64'(err_cnt), 64'hFFFF);
    check("t7_sticky", 64'(err_sticky), 64'd1);
    axi.axi_str_tvalid = 1'b0;
    do_reset();
    tick();
    check("final_reset_err_cnt", 64'(err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
